// File: rtl/cdclib_lvlsync_filt.sv
// Multi-bit level synchronizer with per-bit persistence filter and qualified edge pulses.
// Every bit is independent, so multi-bit coded values must not be passed through this block.

module cdclib_lvlsync_filt #(
  parameter int unsigned DWIDTH       = 1,
  parameter int unsigned SYNCSTAGE    = 4,
  parameter int unsigned ACTIVE_LEVEL = 1,
  parameter int unsigned FILT_CYCLES  = 4,
  parameter int unsigned PULSE_EDGE   = 0
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              filt_bypass,
  output logic [DWIDTH-1:0] data_out,
  output logic [DWIDTH-1:0] pulse_out
);

  localparam int unsigned       CW       = $clog2(FILT_CYCLES + 1);
  localparam logic              ActLvl   = (ACTIVE_LEVEL != 0);
  localparam logic [DWIDTH-1:0] RstVal   = {DWIDTH{~ActLvl}};
  localparam logic [CW-1:0]     CntLast  = CW'(FILT_CYCLES - 1);

  logic [DWIDTH-1:0] sync_q [SYNCSTAGE];
  logic [DWIDTH-1:0] sync_lvl;
  logic [CW-1:0]     cnt_q  [DWIDTH];
  logic [CW-1:0]     cnt_d  [DWIDTH];
  logic [DWIDTH-1:0] data_q, data_d;
  logic [DWIDTH-1:0] pulse_q, pulse_d;
  logic [DWIDTH-1:0] chg, now_active;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int k = 0; k < int'(SYNCSTAGE); k++) sync_q[k] <= RstVal;
    end else begin
      sync_q[0] <= data_in;
      for (int k = 1; k < int'(SYNCSTAGE); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_lvl = sync_q[SYNCSTAGE-1];

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < int'(DWIDTH); i++) begin
      cnt_d[i] = '0;
      if (filt_bypass) begin
        data_d[i] = sync_lvl[i];
      end else if (sync_lvl[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        data_d[i] = sync_lvl[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Pulse is registered alongside data_q so it lines up with the visible change.
  always_comb begin
    chg        = data_d ^ data_q;
    now_active = data_d ~^ {DWIDTH{ActLvl}};
    if (PULSE_EDGE == 1) begin
      pulse_d = chg & now_active;
    end else if (PULSE_EDGE == 2) begin
      pulse_d = chg & ~now_active;
    end else begin
      pulse_d = chg;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      data_q  <= RstVal;
      pulse_q <= '0;
      for (int i = 0; i < int'(DWIDTH); i++) cnt_q[i] <= '0;
    end else begin
      data_q  <= data_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < int'(DWIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_out  = data_q;
  assign pulse_out = pulse_q;

endmodule

// File: tb/tb_cdclib_lvlsync_filt.sv
// Bench for cdclib_lvlsync_filt: three configurations driven in parallel, checked against a
// sliding-window model every cycle plus directed literal expectations.

module tb_cdclib_lvlsync_filt;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       byp;
  logic [3:0] dout [3];
  logic [3:0] pout [3];

  int n_chk  = 0;
  int n_fail = 0;

  // Instance 0: default test config; 1: active-low; 2: rising-only pulses.
  cdclib_lvlsync_filt #(
    .DWIDTH(4), .SYNCSTAGE(3), .ACTIVE_LEVEL(1), .FILT_CYCLES(4), .PULSE_EDGE(0)
  ) u_dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .data_in(data_in), .filt_bypass(byp),
    .data_out(dout[0]), .pulse_out(pout[0])
  );

  cdclib_lvlsync_filt #(
    .DWIDTH(4), .SYNCSTAGE(3), .ACTIVE_LEVEL(0), .FILT_CYCLES(4), .PULSE_EDGE(0)
  ) u_dut_al0 (
    .rd_clk(clk), .rd_rst_n(rst_n), .data_in(data_in), .filt_bypass(byp),
    .data_out(dout[1]), .pulse_out(pout[1])
  );

  cdclib_lvlsync_filt #(
    .DWIDTH(4), .SYNCSTAGE(3), .ACTIVE_LEVEL(1), .FILT_CYCLES(4), .PULSE_EDGE(1)
  ) u_dut_pe1 (
    .rd_clk(clk), .rd_rst_n(rst_n), .data_in(data_in), .filt_bypass(byp),
    .data_out(dout[2]), .pulse_out(pout[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rv(input int k);
    return (k == 1) ? 4'hF : 4'h0;
  endfunction

  // Model: s is data_in from three edges ago; a bit is accepted once the last four filtered
  // samples since the most recent bypass/reset all differ from the current output.
  logic [3:0] sq  [3][3];
  logic [3:0] win [3][4];
  int         wlen [3];
  logic [3:0] m_out [3];
  logic [3:0] m_pulse [3];

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] s, nw, chg, act_now;
    logic       all_diff;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++) sq[k][j] = rv(k);
        m_out[k] = rv(k);
        m_pulse[k] = 4'h0;
        wlen[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        s = sq[k][2];
        sq[k][2] = sq[k][1];
        sq[k][1] = sq[k][0];
        sq[k][0] = data_in;
        nw = m_out[k];
        if (byp) begin
          nw = s;
          wlen[k] = 0;
        end else begin
          for (int j = 3; j > 0; j--) win[k][j] = win[k][j-1];
          win[k][0] = s;
          if (wlen[k] < 4) wlen[k]++;
          for (int b = 0; b < 4; b++) begin
            all_diff = (wlen[k] == 4);
            for (int j = 0; j < 4; j++) if (win[k][j][b] == m_out[k][b]) all_diff = 1'b0;
            if (all_diff) nw[b] = s[b];
          end
        end
        chg = nw ^ m_out[k];
        act_now = (k == 1) ? ~nw : nw;
        m_pulse[k] = (k == 2) ? (chg & act_now) : chg;
        m_out[k] = nw;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_dout[%0d]", k), 32'(dout[k]), 32'(m_out[k]));
      chk($sformatf("model_pulse[%0d]", k), 32'(pout[k]), 32'(m_pulse[k]));
    end
  end

  // Edge index (0 = first sampling edge) at which instance 0 shows val; -1 if never.
  task automatic wait_change(input logic [3:0] val, output int n);
    bit done;
    n = -1;
    done = 1'b0;
    for (int e = 0; e < 30 && !done; e++) begin
      @(posedge clk);
      #1;
      if (dout[0] == val) begin
        n = e;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int n, bad, pc, hc;
    logic [3:0] wp;
    logic [7:0] hi, pu;
    rst_n = 1'b1;
    data_in = 4'hF;
    byp = 1'b0;
    #1 rst_n = 1'b0;

    // Reset holds outputs regardless of input
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout[0]), 32'h0);
    chk("rst_pulse", 32'(pout[0]), 32'h0);
    chk("rst_dout_al0", 32'(dout[1]), 32'hF);
    data_in = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Step 0 -> 5
    data_in = 4'h5;
    wait_change(4'h5, n);
    chk("step_latency", 32'(n), 32'd6);
    chk("step_pulse", 32'(pout[0]), 32'h5);
    @(posedge clk);
    #1 chk("step_pulse_end", 32'(pout[0]), 32'h0);
    @(negedge clk) data_in = 4'h0;
    repeat (12) @(negedge clk);

    // Three-cycle glitch is filtered out
    data_in = 4'h1;
    repeat (3) @(negedge clk);
    data_in = 4'h0;
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (dout[0] != 4'h0 || pout[0] != 4'h0) bad++;
    end
    chk("glitch3_ignored", 32'(bad), 32'd0);

    // Four-cycle pulse is accepted with one pulse (fall-back lands after the window)
    @(negedge clk) data_in = 4'h1;
    pc = 0;
    hc = 0;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #1;
      if (pout[0] != 4'h0) pc++;
      if (dout[0] == 4'h1) hc++;
      if (e == 3) @(negedge clk) data_in = 4'h0;
    end
    chk("glitch4_pulses", 32'(pc), 32'd1);
    chk("glitch4_high_cycles", 32'(hc), 32'd3);
    repeat (12) @(negedge clk);

    // Rising-only pulse instance
    data_in = 4'hA;
    pc = 0;
    wp = 4'h0;
    repeat (10) begin
      @(posedge clk);
      #1 if (pout[2] != 4'h0) begin pc++; wp = pout[2]; end
    end
    chk("pe1_rise_pulse", 32'(wp), 32'hA);
    chk("pe1_rise_count", 32'(pc), 32'd1);
    chk("pe1_rise_dout", 32'(dout[2]), 32'hA);
    @(negedge clk) data_in = 4'h0;
    pc = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (pout[2] != 4'h0) pc++;
    end
    chk("pe1_fall_pulses", 32'(pc), 32'd0);
    chk("pe1_fall_dout", 32'(dout[2]), 32'h0);

    // Bypass passes a one-cycle glitch on bit 2
    @(negedge clk) byp = 1'b1;
    repeat (5) @(negedge clk);
    data_in = 4'h4;
    hi = '0;
    pu = '0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      hi[e] = dout[0][2];
      pu[e] = pout[0][2];
      if (e == 0) @(negedge clk) data_in = 4'h0;
    end
    chk("bypass_high", 32'(hi), 32'h08);
    chk("bypass_pulses", 32'(pu), 32'h18);

    // Dropping bypass before the change reaches s: filter starts counting from zero
    @(negedge clk) data_in = 4'h4;
    n = -1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1 if (n < 0 && dout[0][2]) n = e;
      if (e == 2) @(negedge clk) byp = 1'b0;
    end
    chk("bypass_clear_latency", 32'(n), 32'd6);
    @(negedge clk) data_in = 4'h0;
    repeat (12) @(negedge clk);

    // Reset mid-count
    data_in = 4'h8;
    repeat (12) @(negedge clk);
    chk("pre_rst_dout", 32'(dout[0]), 32'h8);
    data_in = 4'h9;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_dout", 32'(dout[0]), 32'h0);
    chk("rst_async_pulse", 32'(pout[0]), 32'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_change(4'h9, n);
    chk("rst_recover_latency", 32'(n), 32'd6);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
